// File: rtl/rns_ct_addsub_engine_pkg.sv
// Shared constants, types and modular helpers for the RNS ciphertext add/sub engine.
package rns_ct_addsub_engine_pkg;

  localparam int NCOEFF  = 8;
  localparam int NPRIMES = 3;
  localparam int WORD    = 32;
  localparam int NLANES  = 4;
  localparam int NREGS   = 8;

  localparam int REG_W   = $clog2(NREGS);
  localparam int NBEATS  = NCOEFF / NLANES * NPRIMES;  // beats per polynomial
  localparam int BEAT_W  = $clog2(NBEATS);
  localparam int PRIME_W = $clog2(NPRIMES);
  localparam int VEC_W   = NLANES * WORD;

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(NBEATS - 1);
  localparam logic [PRIME_W-1:0] LAST_PRIME = PRIME_W'(NPRIMES - 1);

  localparam logic [WORD-1:0] Q_MODULI   [NPRIMES] = '{32'd97, 32'd193, 32'd257};
  localparam logic [WORD-1:0] DELTA_MODQ [NPRIMES] = '{32'd12, 32'd45, 32'd200};

  typedef logic [VEC_W-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    MODE_ADD    = 2'd0,
    MODE_SUB    = 2'd1,
    MODE_PT_ADD = 2'd2,
    MODE_RSVD   = 2'd3
  } op_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Operands are assumed already reduced below q.
  function automatic logic [WORD-1:0] add_mod(input logic [WORD-1:0] a,
                                               input logic [WORD-1:0] b,
                                               input logic [WORD-1:0] q);
    logic [WORD:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[WORD-1:0];
  endfunction

  function automatic logic [WORD-1:0] sub_mod(input logic [WORD-1:0] a,
                                               input logic [WORD-1:0] b,
                                               input logic [WORD-1:0] q);
    return (a >= b) ? (a - b) : (a - b + q);
  endfunction

endpackage

// File: rtl/rns_ct_addsub_engine_mod_mul.sv
// Two-stage pipelined (a*b) mod q: stage 1 holds the full product, stage 2 the residue.
module rns_mod_mul #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  output logic [W-1:0] p
);

  logic [2*W-1:0] prod;
  logic [W-1:0]   q_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod <= '0;
      q_d  <= '0;
      p    <= '0;
    end else begin
      prod <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
      q_d  <= q;
      p    <= (q_d == '0) ? '0 : W'(prod % {{W{1'b0}}, q_d});
    end
  end

endmodule

// File: rtl/rns_ct_addsub_engine.sv
// Streaming RNS ciphertext add/sub engine: issues regfile reads, runs a fixed
// 4-cycle lane pipeline and writes results back beat by beat.
module rns_ct_addsub_engine
  import rns_ct_addsub_engine_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_mode,
  input  logic [REG_W-1:0]  op_src1,
  input  logic [REG_W-1:0]  op_src2,
  input  logic [REG_W-1:0]  op_dst,
  output logic              rd_en,
  output logic [REG_W-1:0]  rd1_idx,
  output logic [REG_W-1:0]  rd2_idx,
  output logic              rd_poly,
  output logic [BEAT_W-1:0] rd_beat,
  input  lane_vec_t         rd1_data,
  input  lane_vec_t         rd2_data,
  output logic              wr_en,
  output logic [REG_W-1:0]  wr_idx,
  output logic              wr_poly,
  output logic [BEAT_W-1:0] wr_beat,
  output lane_vec_t         wr_data,
  output logic              done_out,
  output logic              err_out,
  output state_e            fsm_state
);

  // Handshake: an op transfers on a rising edge where op_valid && op_ready;
  // op_ready is only high in IDLE, so op_valid is ignored everywhere else.

  state_e             state;
  op_mode_e           mode_r;
  logic [PRIME_W-1:0] prime;

  logic               m0_v, m0_poly, s1_v, s1_poly, s2_v, s2_poly;
  logic [BEAT_W-1:0]  m0_beat, s1_beat, s2_beat;
  logic [PRIME_W-1:0] m0_prime, s1_prime, s2_prime;
  lane_vec_t          s1_a, s1_b, s2_a, s2_b, mul_p, result;
  logic [WORD-1:0]    q_s2, lane_a, lane_b, lane_m;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      mode_r   <= MODE_ADD;
      op_ready <= 1'b0;
      rd_en    <= 1'b0;
      rd1_idx  <= '0;
      rd2_idx  <= '0;
      wr_idx   <= '0;
      rd_poly  <= 1'b0;
      rd_beat  <= '0;
      prime    <= '0;
      done_out <= 1'b0;
      err_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      err_out  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid && op_ready) begin
            op_ready <= 1'b0;
            mode_r   <= op_mode_e'(op_mode);
            rd1_idx  <= op_src1;
            rd2_idx  <= op_src2;
            wr_idx   <= op_dst;
            if (op_mode_e'(op_mode) == MODE_RSVD) begin
              state    <= ST_DONE;
              done_out <= 1'b1;
              err_out  <= 1'b1;
            end else begin
              state   <= ST_ISSUE;
              rd_en   <= 1'b1;
              rd_poly <= 1'b0;
              rd_beat <= '0;
              prime   <= '0;
            end
          end else begin
            op_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (rd_poly && rd_beat == LAST_BEAT) begin
            state   <= ST_DRAIN;
            rd_en   <= 1'b0;
            rd_poly <= 1'b0;
            rd_beat <= '0;
            prime   <= '0;
          end else if (rd_beat == LAST_BEAT) begin
            rd_poly <= 1'b1;
            rd_beat <= '0;
            prime   <= '0;
          end else begin
            rd_beat <= rd_beat + 1'b1;
            prime   <= (prime == LAST_PRIME) ? '0 : prime + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Reads have stopped, so the pipeline is empty behind the last write.
          if (wr_en && !m0_v && !s1_v && !s2_v) begin
            state    <= ST_DONE;
            done_out <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

  // m0 tracks the read in flight; s1/s2 align with the multiplier stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_v <= 1'b0; m0_poly <= 1'b0; m0_beat <= '0; m0_prime <= '0;
      s1_v <= 1'b0; s1_poly <= 1'b0; s1_beat <= '0; s1_prime <= '0;
      s2_v <= 1'b0; s2_poly <= 1'b0; s2_beat <= '0; s2_prime <= '0;
      s1_a <= '0; s1_b <= '0; s2_a <= '0; s2_b <= '0;
      wr_en <= 1'b0; wr_poly <= 1'b0; wr_beat <= '0; wr_data <= '0;
    end else begin
      m0_v <= rd_en; m0_poly <= rd_poly; m0_beat <= rd_beat; m0_prime <= prime;
      s1_v <= m0_v;  s1_poly <= m0_poly; s1_beat <= m0_beat; s1_prime <= m0_prime;
      s1_a <= rd1_data;
      s1_b <= rd2_data;
      s2_v <= s1_v;  s2_poly <= s1_poly; s2_beat <= s1_beat; s2_prime <= s1_prime;
      s2_a <= s1_a;
      s2_b <= s1_b;
      wr_en   <= s2_v;
      wr_poly <= s2_poly;
      wr_beat <= s2_beat;
      wr_data <= result;
    end
  end

  for (genvar g = 0; g < NLANES; g++) begin : g_mul
    rns_mod_mul #(.W(WORD)) u_mul (
      .clk   (clk),
      .reset (reset),
      .a     (rd2_data[g*WORD +: WORD]),
      .b     (DELTA_MODQ[m0_prime]),
      .q     (Q_MODULI[m0_prime]),
      .p     (mul_p[g*WORD +: WORD])
    );
  end

  always_comb begin
    result = '0;
    q_s2   = Q_MODULI[s2_prime];
    lane_a = '0;
    lane_b = '0;
    lane_m = '0;
    for (int l = 0; l < NLANES; l++) begin
      lane_a = s2_a[l*WORD +: WORD];
      lane_b = s2_b[l*WORD +: WORD];
      lane_m = mul_p[l*WORD +: WORD];
      case (mode_r)
        MODE_SUB:    result[l*WORD +: WORD] = sub_mod(lane_a, lane_b, q_s2);
        MODE_PT_ADD: result[l*WORD +: WORD] = s2_poly ? add_mod(lane_a, lane_m, q_s2) : lane_a;
        default:     result[l*WORD +: WORD] = add_mod(lane_a, lane_b, q_s2);
      endcase
    end
  end

endmodule

// File: tb/tb_rns_ct_addsub_engine.sv
// Bench for rns_ct_addsub_engine: regfile model, arithmetic reference, write scoreboard.
module tb_rns_ct_addsub_engine;
  import rns_ct_addsub_engine_pkg::*;

  localparam int EW = REG_W + 1 + BEAT_W + VEC_W;

  logic              clk, reset, op_valid, op_ready;
  logic [1:0]        op_mode;
  logic [REG_W-1:0]  op_src1, op_src2, op_dst;
  logic              rd_en, rd_poly;
  logic [REG_W-1:0]  rd1_idx, rd2_idx;
  logic [BEAT_W-1:0] rd_beat;
  lane_vec_t         rd1_data, rd2_data;
  logic              wr_en, wr_poly;
  logic [REG_W-1:0]  wr_idx;
  logic [BEAT_W-1:0] wr_beat;
  lane_vec_t         wr_data;
  logic              done_out, err_out;
  state_e            fsm_state;

  lane_vec_t      mem [NREGS][2][NBEATS];
  longint         ref_mem [NREGS][2][NBEATS][NLANES];
  longint         tq [3] = '{97, 193, 257};
  longint         td [3] = '{12, 45, 200};
  logic [EW-1:0]  exp_q [$];
  int             n_tests = 0;
  int             n_fail  = 0;
  int             wr_count = 0;

  rns_ct_addsub_engine dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_mode(op_mode), .op_src1(op_src1), .op_src2(op_src2), .op_dst(op_dst),
    .rd_en(rd_en), .rd1_idx(rd1_idx), .rd2_idx(rd2_idx), .rd_poly(rd_poly),
    .rd_beat(rd_beat), .rd1_data(rd1_data), .rd2_data(rd2_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_poly(wr_poly), .wr_beat(wr_beat),
    .wr_data(wr_data), .done_out(done_out), .err_out(err_out), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // regfile model: read data registered one cycle after rd_en, read-before-write
  always @(posedge clk) begin
    if (rd_en) begin
      rd1_data <= mem[rd1_idx][rd_poly][rd_beat];
      rd2_data <= mem[rd2_idx][rd_poly][rd_beat];
    end
    if (wr_en) mem[wr_idx][wr_poly][wr_beat] = wr_data;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write is popped and compared in order
  always @(negedge clk) begin
    if (wr_en) begin
      logic [EW-1:0] e;
      int idx, pl, bt;
      wr_count++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {wr_idx, wr_poly, wr_beat}, e[EW-1:VEC_W]);
        check("wr_data", wr_data, e[VEC_W-1:0]);
        idx = int'(e[VEC_W+BEAT_W+1 +: REG_W]);
        pl  = int'(e[VEC_W+BEAT_W]);
        bt  = int'(e[VEC_W +: BEAT_W]);
        for (int l = 0; l < NLANES; l++) ref_mem[idx][pl][bt][l] = longint'(e[l*WORD +: WORD]);
      end
    end
  end

  task automatic fill_const(input int idx, input int pl, input longint val);
    for (int b = 0; b < NBEATS; b++)
      for (int l = 0; l < NLANES; l++) begin
        ref_mem[idx][pl][b][l] = val;
        mem[idx][pl][b][l*WORD +: WORD] = WORD'(val);
      end
  endtask

  // pt entries hold the same plaintext in both polys
  task automatic fill_rand(input int idx, input bit same_polys);
    longint v;
    for (int b = 0; b < NBEATS; b++)
      for (int l = 0; l < NLANES; l++)
        for (int pl = 0; pl < 2; pl++) begin
          if (pl == 0 || !same_polys) v = longint'($urandom_range(0, 32'(tq[b % NPRIMES] - 1)));
          ref_mem[idx][pl][b][l] = v;
          mem[idx][pl][b][l*WORD +: WORD] = WORD'(v);
        end
  endtask

  function automatic lane_vec_t pack_ref(input int idx, input int pl, input int b);
    lane_vec_t v;
    v = '0;
    for (int l = 0; l < NLANES; l++) v[l*WORD +: WORD] = WORD'(ref_mem[idx][pl][b][l]);
    return v;
  endfunction

  function automatic logic [WORD-1:0] lane_of(input int idx, input int pl, input int b, input int l);
    lane_vec_t v;
    v = mem[idx][pl][b];
    return v[l*WORD +: WORD];
  endfunction

  // reference: whole-op result from the pre-op register contents
  task automatic model_op(input int mode, input int s1, input int s2, input int d);
    longint a, b, pt, q, r;
    lane_vec_t v;
    for (int pl = 0; pl < 2; pl++)
      for (int bt = 0; bt < NBEATS; bt++) begin
        q = tq[bt % NPRIMES];
        v = '0;
        for (int l = 0; l < NLANES; l++) begin
          a  = ref_mem[s1][pl][bt][l];
          b  = ref_mem[s2][pl][bt][l];
          pt = ref_mem[s2][0][bt][l];
          case (mode)
            0:       r = (a + b) % q;
            1:       r = (a - b + q) % q;
            default: r = (pl == 0) ? a : (a + (pt * td[bt % NPRIMES]) % q) % q;
          endcase
          v[l*WORD +: WORD] = WORD'(r);
        end
        exp_q.push_back({REG_W'(d), 1'(pl), BEAT_W'(bt), v});
      end
  endtask

  // driver: waits for op_ready and returns #1 after the accepting edge
  task automatic start_op(input int mode, input int s1, input int s2, input int d);
    int n;
    @(negedge clk);
    op_valid = 1'b1;
    op_mode  = 2'(mode);
    op_src1  = REG_W'(s1);
    op_src2  = REG_W'(s2);
    op_dst   = REG_W'(d);
    n = 0;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) check("ready_timeout", 0, 1);
    if (mode != 3) model_op(mode, s1, s2, d);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int exp_writes, input int exp_lat, input bit exp_err);
    int k, fw, nw;
    bit seen;
    k = 0; fw = -1; nw = 0; seen = 1'b0;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (wr_en) begin
        nw++;
        if (fw < 0) fw = k;
      end
      if (done_out) begin
        seen = 1'b1;
        check("err_out", err_out, exp_err);
      end
    end
    check("done_seen", seen, 1);
    check("done_lat", k, exp_lat);
    check("wr_pulses", nw, exp_writes);
    if (exp_writes > 0) check("first_wr_lat", fw, 5);
    @(negedge clk);
    check("ready_back", op_ready, 1);
  endtask

  task automatic compare_entry(input int d);
    for (int pl = 0; pl < 2; pl++)
      for (int b = 0; b < NBEATS; b++) check("dst_entry", mem[d][pl][b], pack_ref(d, pl, b));
  endtask

  task automatic run_op(input int mode, input int s1, input int s2, input int d);
    start_op(mode, s1, s2, d);
    op_valid = 1'b0;
    if (mode == 3) wait_done(0, 1, 1'b1);
    else           wait_done(2 * NBEATS, 17, 1'b0);
    check("exp_q_empty", exp_q.size(), 0);
    if (mode != 3) compare_entry(d);
  endtask

  initial begin
    int w0, m, s1, s2, d;
    reset = 1'b0; op_valid = 1'b0; op_mode = 2'd0;
    op_src1 = '0; op_src2 = '0; op_dst = '0;
    rd1_data = '0; rd2_data = '0;
    for (int i = 0; i < 7; i++) fill_rand(i, 1'b0);
    fill_rand(7, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_op_ready", op_ready, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_done_err", {done_out, err_out}, 0);
    check("rst_addr", {rd1_idx, rd2_idx, rd_poly, rd_beat, wr_idx, wr_poly, wr_beat}, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_state", fsm_state, ST_IDLE);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", op_ready, 1);

    // directed arithmetic
    fill_const(1, 0, 5); fill_const(1, 1, 10);
    fill_const(2, 0, 7); fill_const(2, 1, 3);
    run_op(0, 1, 2, 3);
    check("add_a", lane_of(3, 0, 4, 3), 12);
    check("add_b", lane_of(3, 1, 5, 0), 13);
    run_op(1, 1, 2, 4);
    check("sub_a_p0", lane_of(4, 0, 0, 1), 95);
    check("sub_a_p1", lane_of(4, 0, 1, 2), 191);
    check("sub_a_p2", lane_of(4, 0, 5, 0), 255);
    check("sub_b", lane_of(4, 1, 3, 3), 7);
    fill_const(7, 0, 4); fill_const(7, 1, 4);
    run_op(2, 1, 7, 5);
    check("pt_a", lane_of(5, 0, 2, 0), 5);
    check("pt_b_p0", lane_of(5, 1, 3, 1), 58);
    check("pt_b_p1", lane_of(5, 1, 4, 2), 190);
    check("pt_b_p2", lane_of(5, 1, 2, 3), 39);
    fill_const(6, 0, 96); fill_const(6, 1, 96);
    run_op(0, 6, 6, 6);
    check("wrap_p0", lane_of(6, 0, 0, 0), 95);
    check("wrap_p1", lane_of(6, 1, 1, 1), 192);
    check("wrap_p2", lane_of(6, 0, 2, 2), 192);

    // back-to-back with op_valid held high, then reserved mode
    start_op(0, 1, 2, 0);
    op_mode = 2'd1; op_dst = REG_W'(3);
    wait_done(2 * NBEATS, 17, 1'b0);
    model_op(1, 1, 2, 3);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    wait_done(2 * NBEATS, 17, 1'b0);
    check("b2b_q_empty", exp_q.size(), 0);
    compare_entry(0);
    compare_entry(3);
    run_op(3, 1, 2, 4);

    // reset mid-op at T+8
    fill_rand(0, 1'b0); fill_rand(1, 1'b0);
    w0 = wr_count;
    start_op(0, 0, 1, 2);
    op_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_outputs", {op_ready, rd_en, wr_en, done_out, err_out}, 0);
    check("abort_wr_data", wr_data, 0);
    check("abort_writes", wr_count - w0, 4);
    check("abort_pending", exp_q.size(), 2 * NBEATS - 4);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_more_wr", wr_count - w0, 4);
    reset = 1'b1;
    compare_entry(2);
    run_op(0, 0, 1, 2);

    // randomized ops
    for (int t = 0; t < 24; t++) begin
      m  = $urandom_range(0, 3);
      s1 = $urandom_range(0, 6);
      s2 = (m == 2) ? 7 : $urandom_range(0, 6);
      d  = $urandom_range(0, 6);
      run_op(m, s1, s2, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
